// File: rtl/aes_cbc_seq.sv
// CBC-mode sequencer driving a single aes_core over a multi-block message.
// Optional abort input enabled by defining AES_CBC_SEQ_ABORT_EN.
module aes_cbc_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             encdec,
    input  logic             keylen,
    input  logic             key_new,
    input  logic [127:0]     iv,
    input  logic [CNT_W-1:0] num_blocks,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             core_init,
    output logic             core_next,
    output logic             core_encdec,
    output logic             core_keylen,
    output logic [127:0]     core_block,
    input  logic             core_ready,
    input  logic [127:0]     core_result,
    input  logic             core_result_valid
`ifdef AES_CBC_SEQ_ABORT_EN
    ,
    input  logic             abort
`endif
);

    typedef enum logic [2:0] {
        IDLE, KINIT, KWAIT, WAIT_IN, BSTART, BWAIT, OUT, DONE
    } state_t;

    state_t           state;
    logic [127:0]     chain;
    logic [127:0]     hold_ct;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nb_q;
    logic             guard;
    logic             abort_go;

    // Abort inside BWAIT holds off until the core is idle again.
    always_comb begin
        abort_go = 1'b0;
`ifdef AES_CBC_SEQ_ABORT_EN
        abort_go = abort && (state != IDLE) && (state != DONE) &&
                   !((state == BWAIT) && (guard || !core_ready));
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            chain       <= '0;
            hold_ct     <= '0;
            cnt         <= '0;
            nb_q        <= '0;
            guard       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            core_init   <= 1'b0;
            core_next   <= 1'b0;
            core_encdec <= 1'b0;
            core_keylen <= 1'b0;
            core_block  <= '0;
        end else if (abort_go) begin
            state     <= DONE;
            done      <= 1'b1;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            core_init <= 1'b0;
            core_next <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        core_encdec <= encdec;
                        core_keylen <= keylen;
                        chain       <= iv;
                        nb_q        <= num_blocks;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        if (key_new) begin
                            state     <= KINIT;
                            core_init <= 1'b1;
                        end else begin
                            state    <= WAIT_IN;
                            in_ready <= (num_blocks != '0);
                        end
                    end
                end
                KINIT: begin
                    core_init <= 1'b0;
                    guard     <= 1'b1;
                    state     <= KWAIT;
                end
                KWAIT: begin
                    if (guard) begin
                        guard <= 1'b0;
                    end else if (core_ready) begin
                        state    <= WAIT_IN;
                        in_ready <= (cnt != nb_q);
                    end
                end
                WAIT_IN: begin
                    if (cnt == nb_q) begin
                        in_ready <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else if (in_valid && in_ready) begin
                        in_ready  <= 1'b0;
                        core_next <= 1'b1;
                        state     <= BSTART;
                        if (core_encdec) begin
                            core_block <= in_data ^ chain;
                        end else begin
                            core_block <= in_data;
                            hold_ct    <= in_data;
                        end
                    end
                end
                BSTART: begin
                    core_next <= 1'b0;
                    guard     <= 1'b1;
                    state     <= BWAIT;
                end
                BWAIT: begin
                    if (guard) begin
                        guard <= 1'b0;
                    end else if (core_ready && core_result_valid) begin
                        out_valid <= 1'b1;
                        state     <= OUT;
                        if (core_encdec) begin
                            out_data <= core_result;
                            chain    <= core_result;
                        end else begin
                            out_data <= core_result ^ chain;
                            chain    <= hold_ct;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        cnt       <= cnt + 1'b1;
                        in_ready  <= ((cnt + 1'b1) != nb_q);
                        state     <= WAIT_IN;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cbc_seq.sv
// Directed bench for aes_cbc_seq; the core is a table-driven stand-in that
// knows the NIST SP800-38A AES-128 CBC block transforms.
module tb_aes_cbc_seq;

    localparam int CNT_W = 16;

    logic             clk, reset_n, start, encdec, keylen, key_new;
    logic [127:0]     iv;
    logic [CNT_W-1:0] num_blocks;
    logic             busy, done, in_valid, in_ready, out_valid, out_ready;
    logic [127:0]     in_data, out_data;
    logic             core_init, core_next, core_encdec, core_keylen;
    logic [127:0]     core_block, core_result;
    logic             core_ready, core_result_valid;
`ifdef AES_CBC_SEQ_ABORT_EN
    logic             abort;
`endif

    aes_cbc_seq #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .encdec(encdec),
        .keylen(keylen), .key_new(key_new), .iv(iv), .num_blocks(num_blocks),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .core_init(core_init), .core_next(core_next),
        .core_encdec(core_encdec), .core_keylen(core_keylen),
        .core_block(core_block), .core_ready(core_ready),
        .core_result(core_result), .core_result_valid(core_result_valid)
`ifdef AES_CBC_SEQ_ABORT_EN
        , .abort(abort)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [127:0] PT [3];
    logic [127:0] CT [3];
    logic [127:0] IV0;

    initial begin
        IV0   = 128'h000102030405060708090a0b0c0d0e0f;
        PT[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
        PT[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        PT[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        CT[0] = 128'h7649abac8119b246cee98e9b12e9197d;
        CT[1] = 128'h5086cb9b507219ee95db113a917678b2;
        CT[2] = 128'h73bed6b8e3c1743b7116e69e22229516;
    end

    // Core stand-in: raw AES input (PT_i ^ prev CT) <-> CT_i for the known vectors.
    logic key_ok = 1'b0;
    always_ff @(posedge clk) if (core_init) key_ok <= 1'b1;

    function automatic logic [127:0] aes_ref(input logic [127:0] b, input logic enc);
        logic [127:0] xin;
        aes_ref = ~b;
        for (int i = 0; i < 3; i++) begin
            xin = PT[i] ^ ((i == 0) ? IV0 : CT[i-1]);
            if (key_ok && enc && b == xin) aes_ref = CT[i];
            if (key_ok && !enc && b == CT[i]) aes_ref = xin;
        end
    endfunction

    logic [2:0] c_cnt;
    logic       c_pend;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_ready <= 1'b1; core_result_valid <= 1'b0; core_result <= '0;
            c_cnt <= '0; c_pend <= 1'b0;
        end else if (c_cnt != 0) begin
            c_cnt <= c_cnt - 1'b1;
            if (c_cnt == 1) begin
                core_ready <= 1'b1;
                core_result_valid <= c_pend;
            end
        end else if (core_init) begin
            core_ready <= 1'b0; core_result_valid <= 1'b0; c_cnt <= 3'd5; c_pend <= 1'b0;
        end else if (core_next) begin
            core_ready <= 1'b0; core_result_valid <= 1'b0; c_cnt <= 3'd4; c_pend <= 1'b1;
            core_result <= aes_ref(core_block, core_encdec);
        end
    end

    int n_init, n_next, n_done, n_out, n_inrdy, n_outv;
    always @(posedge clk) begin
        if (core_init) n_init++;
        if (core_next) n_next++;
        if (done) n_done++;
        if (out_valid && out_ready) n_out++;
        if (in_ready) n_inrdy++;
        if (out_valid) n_outv++;
    end

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic clr_mon();
        n_init = 0; n_next = 0; n_done = 0; n_out = 0; n_inrdy = 0; n_outv = 0;
    endtask

    task automatic do_start(input logic enc, input logic kn, input logic [127:0] v,
                            input logic [CNT_W-1:0] nb);
        @(negedge clk);
        start = 1'b1; encdec = enc; keylen = 1'b0; key_new = kn; iv = v; num_blocks = nb;
        @(negedge clk);
        start = 1'b0; iv = ~v; encdec = ~enc; num_blocks = nb + 1'b1;
    endtask

    task automatic send_block(input logic [127:0] d, input string tag);
        int t;
        in_valid = 1'b1; in_data = d; t = 0;
        while (!in_ready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk({tag, "_in_timeout"}, 1, 0);
        @(negedge clk);
        in_valid = 1'b0; in_data = '0;
        chk({tag, "_next_lat"}, core_next, 1);
    endtask

    task automatic recv_block(output logic [127:0] d, input string tag);
        int t;
        t = 0;
        while (!out_valid && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk({tag, "_out_timeout"}, 1, 0);
        d = out_data;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (busy && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk({tag, "_idle_timeout"}, 1, 0);
    endtask

    logic [127:0] r, hold;
    logic         stable_ok, rdy_low;

    initial begin
        reset_n = 1'b0; start = 0; encdec = 0; keylen = 0; key_new = 0; iv = '0;
        num_blocks = '0; in_valid = 0; in_data = '0; out_ready = 0;
`ifdef AES_CBC_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_core_init", core_init, 0);
        chk("rst_core_next", core_next, 0);
        chk("rst_core_block", core_block, 0);
        chk("rst_core_encdec", core_encdec, 0);
        reset_n = 1'b1;

        // Encrypt two blocks with key expansion
        clr_mon();
        do_start(1'b1, 1'b1, IV0, 16'd2);
        chk("enc_busy", busy, 1);
        chk("enc_core_encdec", core_encdec, 1);
        send_block(PT[0], "enc0"); recv_block(r, "enc0"); chk("enc_ct0", r, CT[0]);
        send_block(PT[1], "enc1"); recv_block(r, "enc1"); chk("enc_ct1", r, CT[1]);
        wait_idle("enc");
        @(negedge clk);
        chk("enc_done_cnt", n_done, 1);
        chk("enc_init_cnt", n_init, 1);
        chk("enc_next_cnt", n_next, 2);
        chk("enc_keylen", core_keylen, 0);

        // Decrypt reusing the expanded key
        clr_mon();
        do_start(1'b0, 1'b0, IV0, 16'd2);
        chk("dec_core_encdec", core_encdec, 0);
        send_block(CT[0], "dec0"); recv_block(r, "dec0"); chk("dec_pt0", r, PT[0]);
        send_block(CT[1], "dec1"); recv_block(r, "dec1"); chk("dec_pt1", r, PT[1]);
        wait_idle("dec");
        @(negedge clk);
        chk("dec_init_cnt", n_init, 0);
        chk("dec_done_cnt", n_done, 1);

        // Zero-length message
        clr_mon();
        do_start(1'b1, 1'b0, IV0, 16'd0);
        chk("nb0_busy", busy, 1);
        chk("nb0_done_c1", done, 0);
        @(negedge clk);
        chk("nb0_done_c2", done, 1);
        @(negedge clk);
        chk("nb0_busy_end", busy, 0);
        chk("nb0_done_end", done, 0);
        chk("nb0_next", n_next, 0);
        chk("nb0_in_ready", n_inrdy, 0);
        chk("nb0_out_valid", n_outv, 0);

        // Output backpressure on the first of three blocks
        clr_mon();
        do_start(1'b1, 1'b0, IV0, 16'd3);
        send_block(PT[0], "bp0");
        while (!out_valid) @(negedge clk);
        hold = out_data; stable_ok = 1'b1; rdy_low = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (out_data !== hold || !out_valid) stable_ok = 1'b0;
            if (in_ready) rdy_low = 1'b0;
        end
        chk("bp_stable", stable_ok, 1);
        chk("bp_in_ready_low", rdy_low, 1);
        recv_block(r, "bp0"); chk("bp_ct0", r, CT[0]);
        send_block(PT[1], "bp1"); recv_block(r, "bp1"); chk("bp_ct1", r, CT[1]);
        send_block(PT[2], "bp2"); recv_block(r, "bp2"); chk("bp_ct2", r, CT[2]);
        wait_idle("bp");

        // Reset while block 2 is in BWAIT
        do_start(1'b1, 1'b0, IV0, 16'd2);
        send_block(PT[0], "rs0"); recv_block(r, "rs0");
        send_block(PT[1], "rs1");
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_core_block", core_block, 0);
        chk("mid_rst_core_encdec", core_encdec, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        do_start(1'b1, 1'b1, IV0, 16'd1);
        send_block(PT[0], "post_rst"); recv_block(r, "post_rst");
        chk("post_rst_ct0", r, CT[0]);
        wait_idle("post_rst");

`ifdef AES_CBC_SEQ_ABORT_EN
        clr_mon();
        do_start(1'b1, 1'b0, IV0, 16'd4);
        send_block(PT[0], "ab0"); recv_block(r, "ab0");
        chk("ab_ct0", r, CT[0]);
        chk("ab_in_ready", in_ready, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_done", done, 1);
        chk("ab_out_valid", out_valid, 0);
        @(negedge clk);
        chk("ab_busy", busy, 0);
        chk("ab_done_end", done, 0);
        chk("ab_outputs", n_out, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
